sparse_sel_gen: RTL and testbench
=================================

SPARSE_SEL_GEN -- requirements
Module: sparse_sel_gen

Interface
REQ-001 SHALL have parameter VEC_LEN, default 16, number of selectable lanes (power of two, 4..16).
REQ-002 SHALL have parameter SEL_WIDTH, default 5, select width; the value 2**(SEL_WIDTH-1) (5'b10000) is the zero-select code.
REQ-003 SHALL have parameter PAD_CYCLES, default 8, fixed beat count per mask when padding is compiled in.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port in_valid  input  1  a mask is offered.
REQ-007 SHALL have port in_mask  input  VEC_LEN  nonzero-lane bitmask (bit i = lane i).
REQ-008 SHALL have port in_ready  output  1  the block can accept a mask this cycle.
REQ-009 SHALL have port out_valid  output  1  out_sel is valid.
REQ-010 SHALL have port out_sel  output  SEL_WIDTH  lane index 0..VEC_LEN-1, or the zero-select code; drives the downstream 17:1 mux select.
REQ-011 SHALL have port out_last  output  1  final beat of the current mask.
REQ-012 SHALL have port out_ready  input  1  the downstream stage consumes the beat.
REQ-013 SHALL have port err_ovf  output  1  sticky padding-overflow flag.

Function
REQ-014 SHALL implement states IDLE and SCAN (plus PAD when padded); IDLE->SCAN on in_valid&&in_ready.
REQ-015 SHALL take a mask on in_valid&&in_ready into a remaining-mask register; first beat out_valid=1 on the next cycle (latency 1).
REQ-016 SHALL drive out_sel = index of the lowest set bit of the remaining mask; on each out_valid&&out_ready that bit is cleared.
REQ-017 SHALL hold out_sel/out_last/out_valid stable while out_valid&&!out_ready.
REQ-018 SHALL assert out_last when the remaining mask has exactly one set bit (unpadded build).
REQ-019 SHALL handle an all-zero mask as exactly one beat: out_sel=zero-select, out_last=1.
REQ-020 SHALL assert in_ready in IDLE, and in SCAN/PAD only in the cycle in which out_last handshakes; this allows back-to-back masks with no bubble.
REQ-021 SHALL return to IDLE after the last-beat handshake when no new mask is accepted in that cycle.
REQ-022 SHALL ignore in_mask bits whose index is >= VEC_LEN.

Reset
REQ-023 SHALL, while rst_n=0, force: state IDLE, remaining mask 0, out_valid=0, out_sel=zero-select, out_last=0, in_ready=1, err_ovf=0.
REQ-024 SHALL let reset mid-mask discard the mask silently; no beat is emitted after reset is released until a new mask is accepted.

Configuration
REQ-025 SHALL define the macro SPARSE_SEL_PAD_EN; when it is defined, every mask produces exactly PAD_CYCLES beats: set bits first, then zero-select beats (PAD state), with out_last on beat PAD_CYCLES.
REQ-026 SHALL, with SPARSE_SEL_PAD_EN defined and popcount > PAD_CYCLES, emit all set bits (no truncation), assert out_last on the final set bit, and set err_ovf until reset.
REQ-027 SHALL, without SPARSE_SEL_PAD_EN, use beat count = max(popcount, 1), omit the PAD state, and tie err_ovf to 0.

Structure
REQ-028 SHALL place the state enum, the zero-select constant and the default VEC_LEN/SEL_WIDTH in shared package bitsim_sel_pkg.
REQ-029 SHALL contain one sub-module, lsb_priority_enc (VEC_LEN-bit lowest-set-bit encoder with found flag), used combinationally.

Verification
REQ-030 SHALL pass: mask 16'h8421, out_ready=1 -> sel 0,5,10,15 on consecutive cycles, last on 15.
REQ-031 SHALL pass: mask 16'h0000 -> single beat sel=5'b10000, last=1.
REQ-032 SHALL pass: mask 16'h0003 with out_ready low 3 cycles -> sel=0 held stable, then 0,1.
REQ-033 SHALL pass: masks 16'h0001 and 16'h0002 back-to-back -> in_ready=1 on the last beat; sel 0 then 1 with no idle cycle.
REQ-034 SHALL pass, with SPARSE_SEL_PAD_EN and PAD_CYCLES=8: mask 16'h0011 -> sel 0,4 then six beats of 5'b10000, last on the 8th; mask 16'h01FF -> nine beats, err_ovf=1.
REQ-035 SHALL pass: rst_n low during the 2nd beat of 16'h00F0 -> out_valid=0 at once; no beats after release until a new mask.

Source files
------------

// File: rtl/bitsim_sel_pkg.sv
// Shared types and constants for the sparse lane-select generator.
package bitsim_sel_pkg;

    localparam int unsigned DefVecLen   = 16;
    localparam int unsigned DefSelWidth = 5;

    // Select code that steers the downstream 17:1 mux to its constant-zero input.
    localparam logic [DefSelWidth-1:0] ZeroSel = 5'b10000;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StPad
    } sel_state_e;

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit encoder: index of the least significant 1 in vec_i, plus a found flag.
module lsb_priority_enc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 5
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = 1'b0;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = IDX_W'(i);
                found_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sparse_sel_gen.sv
// Walks the set lanes of a sparse mask, one select per beat, lowest lane first.
// Define SPARSE_SEL_PAD_EN to pad every mask to PAD_CYCLES beats with zero-selects.
module sparse_sel_gen
    import bitsim_sel_pkg::*;
#(
    parameter int unsigned VEC_LEN    = DefVecLen,
    parameter int unsigned SEL_WIDTH  = DefSelWidth,
    parameter int unsigned PAD_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [VEC_LEN-1:0]   in_mask,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [SEL_WIDTH-1:0] out_sel,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 err_ovf
);

    localparam logic [SEL_WIDTH-1:0] ZeroCode = {1'b1, {(SEL_WIDTH - 1){1'b0}}};

    sel_state_e         state_q, state_d;
    logic [VEC_LEN-1:0] rem_q, rem_d;
    logic [SEL_WIDTH-1:0] lsb_idx;
    logic               lsb_found;
    logic               rem_single;
    logic               beat_full;
    logic               beat_hs;
    logic               accept;

    lsb_priority_enc #(
        .WIDTH (VEC_LEN),
        .IDX_W (SEL_WIDTH)
    ) u_lsb_enc (
        .vec_i   (rem_q),
        .idx_o   (lsb_idx),
        .found_o (lsb_found)
    );

    // True for zero or exactly one bit remaining.
    assign rem_single = (rem_q & (rem_q - VEC_LEN'(1))) == '0;

    assign out_valid = (state_q != StIdle);
    assign out_sel   = lsb_found ? lsb_idx : ZeroCode;
    assign out_last  = out_valid && rem_single && beat_full;
    assign beat_hs   = out_valid && out_ready;
    assign in_ready  = (state_q == StIdle) || (beat_hs && out_last);
    assign accept    = in_valid && in_ready;

`ifdef SPARSE_SEL_PAD_EN
    localparam bit          PadEn = 1'b1;
    localparam int unsigned CntW  = $clog2(PAD_CYCLES + 1);

    logic [CntW-1:0] beat_q, beat_d;
    logic            err_q, err_d;

    // Saturates on the final padded beat; overflowing masks keep scanning past it.
    assign beat_full = (beat_q == CntW'(PAD_CYCLES - 1));
    assign err_ovf   = err_q;

    always_comb begin
        beat_d = beat_q;
        err_d  = err_q;
        if (beat_hs && !beat_full) begin
            beat_d = beat_q + CntW'(1);
        end
        if (accept) begin
            beat_d = '0;
            if ($countones(in_mask) > PAD_CYCLES) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_q <= '0;
            err_q  <= 1'b0;
        end else begin
            beat_q <= beat_d;
            err_q  <= err_d;
        end
    end
`else
    localparam bit PadEn = 1'b0;

    assign beat_full = 1'b1;
    assign err_ovf   = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        if (beat_hs) begin
            rem_d = rem_q & (rem_q - VEC_LEN'(1));
            if (out_last) begin
                state_d = StIdle;
            end else if (PadEn && rem_single) begin
                state_d = StPad;
            end
        end
        // A new mask accepted on the last-beat handshake overrides the return to idle.
        if (accept) begin
            rem_d   = in_mask;
            state_d = (PadEn && (in_mask == '0)) ? StPad : StScan;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

endmodule

// File: tb/tb_sparse_sel_gen.sv
// Self-checking bench for sparse_sel_gen: directed cases plus randomized traffic vs a beat-queue model.
module tb_sparse_sel_gen;
    import bitsim_sel_pkg::*;

    localparam int unsigned VecLen    = 16;
    localparam int unsigned SelW      = 5;
    localparam int unsigned PadCycles = 8;
`ifdef SPARSE_SEL_PAD_EN
    localparam bit PadOn = 1'b1;
`else
    localparam bit PadOn = 1'b0;
`endif

    typedef struct packed {
        logic [SelW-1:0] sel;
        logic            last;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic [VecLen-1:0] in_mask;
    logic              in_ready;
    logic              out_valid;
    logic [SelW-1:0]   out_sel;
    logic              out_last;
    logic              out_ready;
    logic              err_ovf;

    beat_t exp_q[$];
    logic  exp_err;
    int    n_cmp;
    int    n_bad;

    sparse_sel_gen #(
        .VEC_LEN    (VecLen),
        .SEL_WIDTH  (SelW),
        .PAD_CYCLES (PadCycles)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_mask   (in_mask),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sel   (out_sel),
        .out_last  (out_last),
        .out_ready (out_ready),
        .err_ovf   (err_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected beats for one mask: ascending set lanes, then zero-selects up to the beat floor.
    function automatic void push_mask(input logic [VecLen-1:0] m);
        beat_t b[$];
        beat_t t;
        int    floor_n;
        floor_n = PadOn ? int'(PadCycles) : 1;
        for (int i = 0; i < int'(VecLen); i++) begin
            if (m[i]) begin
                t.sel  = SelW'(i);
                t.last = 1'b0;
                b.push_back(t);
            end
        end
        while (b.size() < floor_n) begin
            t.sel  = ZeroSel;
            t.last = 1'b0;
            b.push_back(t);
        end
        t      = b.pop_back();
        t.last = 1'b1;
        b.push_back(t);
        foreach (b[i]) exp_q.push_back(b[i]);
        if (PadOn && ($countones(m) > PadCycles)) exp_err = 1'b1;
    endfunction

    // One clock: drive at negedge, check at negedge+1, advance the model at posedge.
    task automatic step(input logic v, input logic [VecLen-1:0] m, input logic rdy,
                        input string tag);
        logic  ev, er, el, hs, acc;
        beat_t head;
        in_valid  = v;
        in_mask   = m;
        out_ready = rdy;
        #1;
        ev   = (exp_q.size() != 0);
        el   = 1'b0;
        head = '0;
        if (ev) begin
            head = exp_q[0];
            el   = head.last;
        end
        er = !ev || (rdy && el);
        check({tag, "/valid"}, 32'(out_valid), 32'(ev));
        check({tag, "/in_ready"}, 32'(in_ready), 32'(er));
        check({tag, "/last"}, 32'(out_last), 32'(el));
        check({tag, "/err"}, 32'(err_ovf), 32'(exp_err));
        if (ev) check({tag, "/sel"}, 32'(out_sel), 32'(head.sel));
        hs  = ev && rdy;
        acc = v && er;
        @(posedge clk);
        if (hs) void'(exp_q.pop_front());
        if (acc) push_mask(m);
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) step(1'b0, '0, 1'b1, tag);
        step(1'b0, '0, 1'b1, tag);
    endtask

    initial begin
        logic              rv, rr;
        logic [VecLen-1:0] rm;
        n_cmp     = 0;
        n_bad     = 0;
        exp_err   = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_mask   = '0;
        out_ready = 1'b0;

        @(negedge clk);
        #1;
        check("rst/valid", 32'(out_valid), 32'(0));
        check("rst/in_ready", 32'(in_ready), 32'(1));
        check("rst/sel", 32'(out_sel), 32'(ZeroSel));
        check("rst/last", 32'(out_last), 32'(0));
        check("rst/err", 32'(err_ovf), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, '0, 1'b1, "idle");

        // Four sparse lanes, free-running sink.
        step(1'b1, 16'h8421, 1'b1, "m8421");
        drain("m8421");

        // Empty mask gives a single zero-select beat.
        step(1'b1, 16'h0000, 1'b1, "m0000");
        drain("m0000");

        // Sink stalls three cycles on the first beat.
        step(1'b1, 16'h0003, 1'b0, "stall");
        repeat (3) step(1'b0, '0, 1'b0, "stall");
        drain("stall");

        // Second mask offered while the first mask's last beat handshakes.
        step(1'b1, 16'h0001, 1'b1, "b2b");
        step(1'b1, 16'h0002, 1'b1, "b2b");
        drain("b2b");

        // Padding/overflow cases (also exercised unpadded).
        step(1'b1, 16'h0011, 1'b1, "m0011");
        drain("m0011");
        step(1'b1, 16'h01FF, 1'b1, "m01FF");
        drain("m01FF");

        for (int k = 0; k < 400; k++) begin
            rv = 1'(($urandom_range(0, 2)) != 0);
            rm = VecLen'($urandom & $urandom);
            if ($urandom_range(0, 7) == 0) rm = '0;
            if ($urandom_range(0, 15) == 0) rm = VecLen'($urandom);
            rr = 1'(($urandom_range(0, 3)) != 0);
            step(rv, rm, rr, "rand");
        end
        drain("rand");

        // Reset lands on the second beat of 16'h00F0.
        step(1'b1, 16'h00F0, 1'b1, "midrst");
        step(1'b0, '0, 1'b1, "midrst");
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check("midrst/valid", 32'(out_valid), 32'(0));
        check("midrst/in_ready", 32'(in_ready), 32'(1));
        check("midrst/sel", 32'(out_sel), 32'(ZeroSel));
        check("midrst/last", 32'(out_last), 32'(0));
        check("midrst/err", 32'(err_ovf), 32'(0));
        exp_q.delete();
        exp_err = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, '0, 1'b1, "postrst");
        step(1'b1, 16'h0001, 1'b1, "postrst");
        drain("postrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
